// File: rtl/fpu_round_pkg.sv
// fpu_round_pkg -- shared definitions for the rounding-exponent arbiter and
// the rounder datapath it feeds.
//   arb_state_e : arbiter FSM states
//   EXP_W/LZ_W  : exponent and leading-zero field widths
//   CNT_W       : latency countdown width (LAT is at most 15)
package fpu_round_pkg;

    localparam int unsigned EXP_W = 11;
    localparam int unsigned LZ_W  = 6;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } arb_state_e;

    // Countdown preload for a datapath of the given latency.
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/round_arbiter_rr_arb2.sv
// rr_arb2 -- two-way round-robin grant with a registered priority pointer.
// Ports:
//   clk, rst : clock, synchronous active-high reset (requester 0 favoured)
//   req      : request vector
//   advance  : the current grant is being taken; rotate priority past it
//   gnt      : one-hot grant (combinational from req and the pointer)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // High when requester 1 wins a tie.
    logic prio1;

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = prio1 ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio1 <= 1'b0;
        end else if (advance && (gnt != '0)) begin
            // The requester just served drops to lowest priority.
            prio1 <= gnt[0];
        end
    end

endmodule

// File: rtl/round_arbiter.sv
// round_arbiter -- shares one exponent-normalize datapath between the add
// (requester 0) and mul (requester 1) units. Grants round-robin, launches the
// datapath, waits LAT cycles, then holds the result until it is consumed.
// Optional feature: define ROUND_ARBITER_STATS_EN to add saturating per-
// requester grant counters grant_cnt0/grant_cnt1.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : per-requester request handshake
//   req_er/lz/db/ovf1/tiny         : per-requester operands
//   ovf_en, unf_en                 : trap enables, sampled at grant
//   dp_start, dp_*                 : datapath launch pulse and operands
//   dp_en, dp_eni                  : datapath results, valid LAT after start
//   res_valid/res_ready            : result handshake
//   res_tag, res_en, res_eni       : owning requester and captured results
module round_arbiter
    import fpu_round_pkg::*;
#(
    parameter int unsigned LAT  = 2,
    parameter int unsigned NREQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][EXP_W-1:0] req_er,
    input  logic [NREQ-1:0][LZ_W-1:0] req_lz,
    input  logic [NREQ-1:0]           req_db,
    input  logic [NREQ-1:0]           req_ovf1,
    input  logic [NREQ-1:0]           req_tiny,
    input  logic                      ovf_en,
    input  logic                      unf_en,
    output logic                      dp_start,
    output logic [EXP_W-1:0]          dp_er,
    output logic [LZ_W-1:0]           dp_lz,
    output logic                      dp_db,
    output logic                      dp_ovf1,
    output logic                      dp_tiny,
    output logic                      dp_ovfen,
    output logic                      dp_unfen,
    input  logic [EXP_W-1:0]          dp_en,
    input  logic [EXP_W-1:0]          dp_eni,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_tag,
`ifdef ROUND_ARBITER_STATS_EN
    output logic [15:0]               grant_cnt0,
    output logic [15:0]               grant_cnt1,
`endif
    output logic [EXP_W-1:0]          res_en,
    output logic [EXP_W-1:0]          res_eni
);

    localparam logic [CNT_W-1:0] CNT_LOAD = lat_load(LAT);

    arb_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt;
    logic             grant;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (grant),
        .gnt     (gnt)
    );

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        req_ready = '0;
        dp_start  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                // Reset wins over a same-cycle request so no grant is lost.
                if (!rst && (req_valid != '0)) begin
                    grant     = 1'b1;
                    req_ready = gnt;
                    state_nx  = ISSUE;
                end
            end
            ISSUE: begin
                dp_start = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dp_er    <= '0;
            dp_lz    <= '0;
            dp_db    <= 1'b0;
            dp_ovf1  <= 1'b0;
            dp_tiny  <= 1'b0;
            dp_ovfen <= 1'b0;
            dp_unfen <= 1'b0;
            res_tag  <= 1'b0;
            res_en   <= '0;
            res_eni  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant) begin
                        dp_er    <= req_er[gnt[1]];
                        dp_lz    <= req_lz[gnt[1]];
                        dp_db    <= req_db[gnt[1]];
                        dp_ovf1  <= req_ovf1[gnt[1]];
                        dp_tiny  <= req_tiny[gnt[1]];
                        dp_ovfen <= ovf_en;
                        dp_unfen <= unf_en;
                        res_tag  <= gnt[1];
                    end
                end
                ISSUE: cnt <= CNT_LOAD;
                WAIT: begin
                    if (cnt == '0) begin
                        res_en  <= dp_en;
                        res_eni <= dp_eni;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ROUND_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            if (gnt[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (gnt[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule

// File: tb/tb_round_arbiter.sv
// tb_round_arbiter -- self-checking bench for round_arbiter. A transaction-
// level reference model tracks, per operation, the cycles elapsed since its
// grant and derives every expected output from that.
module tb_round_arbiter;

    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][10:0] req_er;
    logic [1:0][5:0]  req_lz;
    logic [1:0]       req_db, req_ovf1, req_tiny;
    logic             ovf_en, unf_en;
    logic             dp_start;
    logic [10:0]      dp_er;
    logic [5:0]       dp_lz;
    logic             dp_db, dp_ovf1, dp_tiny, dp_ovfen, dp_unfen;
    logic [10:0]      dp_en, dp_eni;
    logic             res_valid, res_ready, res_tag;
    logic [10:0]      res_en, res_eni;
`ifdef ROUND_ARBITER_STATS_EN
    logic [15:0]      grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    round_arbiter #(.LAT(LAT), .NREQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_er(req_er), .req_lz(req_lz), .req_db(req_db),
        .req_ovf1(req_ovf1), .req_tiny(req_tiny),
        .ovf_en(ovf_en), .unf_en(unf_en),
        .dp_start(dp_start), .dp_er(dp_er), .dp_lz(dp_lz), .dp_db(dp_db),
        .dp_ovf1(dp_ovf1), .dp_tiny(dp_tiny), .dp_ovfen(dp_ovfen),
        .dp_unfen(dp_unfen), .dp_en(dp_en), .dp_eni(dp_eni),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
`ifdef ROUND_ARBITER_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .res_en(res_en), .res_eni(res_eni)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: one operation at a time, "since" counts cycles from
    // its grant (1 = launch cycle, LAT+1 = capture cycle, >= LAT+2 = holding).
    bit          m_busy;
    int          m_since;
    int          m_last;
    logic        m_tag;
    logic [10:0] m_er, m_en, m_eni;
    logic [5:0]  m_lz;
    logic [4:0]  m_flags;
    int          m_cnt[2];
    logic [1:0]  m_granted;
    int          gq[$];

    task automatic model_reset();
        m_busy = 0; m_since = 0; m_last = 1; m_tag = 0;
        m_er = '0; m_en = '0; m_eni = '0; m_lz = '0; m_flags = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int i);
        req_er[i]   = 11'($urandom);
        req_lz[i]   = 6'($urandom);
        req_db[i]   = 1'($urandom);
        req_ovf1[i] = 1'($urandom);
        req_tiny[i] = 1'($urandom);
    endtask

    // One clock cycle: check outputs against the model, clock, update model.
    task automatic cycle();
        logic [1:0] exp_ready;
        int w;
        #1;
        exp_ready = '0;
        w = -1;
        if (!rst && !m_busy && req_valid != 2'b00) begin
            if (req_valid == 2'b11) w = (m_last == 0) ? 1 : 0;
            else                    w = req_valid[1] ? 1 : 0;
            exp_ready[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("dp_start",  32'(dp_start),  32'(m_busy && m_since == 1));
        check("res_valid", 32'(res_valid), 32'(m_busy && m_since >= LAT + 2));
        check("res_tag",   32'(res_tag),   32'(m_tag));
        check("res_en",    32'(res_en),    32'(m_en));
        check("res_eni",   32'(res_eni),   32'(m_eni));
        check("dp_er",     32'(dp_er),     32'(m_er));
        check("dp_lz",     32'(dp_lz),     32'(m_lz));
        check("dp_flags",  32'({dp_db, dp_ovf1, dp_tiny, dp_ovfen, dp_unfen}), 32'(m_flags));
`ifdef ROUND_ARBITER_STATS_EN
        check("grant_cnt0", 32'(grant_cnt0), 32'((m_cnt[0] > 65535) ? 65535 : m_cnt[0]));
        check("grant_cnt1", 32'(grant_cnt1), 32'((m_cnt[1] > 65535) ? 65535 : m_cnt[1]));
`endif
        m_granted = exp_ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (w >= 0) begin
            m_busy = 1; m_since = 1; m_last = w; m_tag = 1'(w);
            m_er = req_er[w]; m_lz = req_lz[w];
            m_flags = {req_db[w], req_ovf1[w], req_tiny[w], ovf_en, unf_en};
            m_cnt[w]++;
            gq.push_back(w);
        end else if (m_busy) begin
            if (m_since == LAT + 1) begin
                m_en = dp_en; m_eni = dp_eni;
            end
            if (m_since >= LAT + 2 && res_ready) m_busy = 0;
            else m_since++;
        end
        #1;
        dp_en  = 11'($urandom);
        dp_eni = 11'($urandom);
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; res_ready = 1'b1;
        ovf_en = 1'b0; unf_en = 1'b0;
        new_req(0); new_req(1);
        dp_en = '0; dp_eni = '0;
        @(posedge clk); #1;
        model_reset();
        // Reset holds off a pending request and clears everything.
        cycle();
        rst = 1'b0; req_valid = 2'b00;
        cycle();

        // Single request from the add unit.
        req_valid = 2'b01; req_er[0] = 11'h3FF; req_lz[0] = 6'd3;
        ovf_en = 1'b1; unf_en = 1'b0;
        cycle();
        req_valid = 2'b00;
        repeat (LAT + 4) cycle();

        // Contention from a fresh reset: grants 0, 1, 0.
        rst = 1'b1; cycle(); rst = 1'b0;
        gq.delete();
        req_valid = 2'b11; new_req(0); new_req(1); ovf_en = 1'b0; unf_en = 1'b1;
        repeat (3 * (LAT + 3)) cycle();
        req_valid = 2'b00;
        check("grant_count", 32'(gq.size()), 32'd3);
        if (gq.size() == 3) begin
            check("grant_order0", 32'(gq[0]), 32'd0);
            check("grant_order1", 32'(gq[1]), 32'd1);
            check("grant_order2", 32'(gq[2]), 32'd0);
        end
        repeat (LAT + 3) cycle();

        // Backpressure in HOLD with another request waiting.
        res_ready = 1'b0; req_valid = 2'b10; new_req(1);
        cycle();
        req_valid = 2'b00;
        repeat (LAT + 2) cycle();
        req_valid = 2'b01; new_req(0);
        repeat (5) cycle();
        res_ready = 1'b1;
        cycle();
        repeat (LAT + 4) cycle();
        req_valid = 2'b00;
        repeat (2) cycle();

        // Reset in the second WAIT cycle aborts the operation.
        req_valid = 2'b01; new_req(0);
        cycle();
        req_valid = 2'b00;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (LAT + 4) cycle();

        // Randomised traffic; unserved requests are held until granted.
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                if (!(req_valid[i] && !m_granted[i])) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    new_req(i);
                end
            end
            ovf_en    = 1'($urandom);
            unf_en    = 1'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/round_arbiter.md
ROUND_ARBITER -- requirements
Module: round_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2: exponent-normalize datapath latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter NREQ, default 2: number of requesters, fixed at 2 in this revision.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  2  per-requester request valid; bit 0 = add unit, bit 1 = mul unit.
REQ-007 req_ready  out  2  per-requester accept; at most one bit high per cycle.
REQ-008 req_er  in  2x11  biased result exponent per requester.
REQ-009 req_lz  in  2x6  leading-zero count per requester.
REQ-010 req_db, req_ovf1, req_tiny  in  2x1 each  per-requester double flag, overflow flag and tiny flag.
REQ-011 ovf_en, unf_en  in  1 each  trap enables, sampled at grant.
REQ-012 dp_start  out  1  one-cycle pulse launching the shared datapath.
REQ-013 dp_er, dp_lz, dp_db, dp_ovf1, dp_tiny, dp_ovfen, dp_unfen  out  11/6/1/1/1/1/1  registered operands to the datapath.
REQ-014 dp_en, dp_eni  in  11 each  datapath results, valid LAT cycles after dp_start.
REQ-015 res_valid  out  1  result valid.
REQ-016 res_ready  in  1  result consumer ready.
REQ-017 res_tag  out  1  index of the requester that owns the result.
REQ-018 res_en, res_eni  out  11 each  captured results.

Function
REQ-019 FSM SHALL have states IDLE, ISSUE, WAIT and HOLD.
REQ-020 IDLE: when any req_valid is high, SHALL grant one requester by round-robin, assert its req_ready for that cycle, capture its operands plus ovf_en and unf_en, and go to ISSUE.
REQ-021 Round-robin: the requester granted last SHALL have lowest priority; after reset bit 0 SHALL have priority; with a single request pending, that request SHALL be granted.
REQ-022 ISSUE: SHALL pulse dp_start for exactly one cycle, load the countdown counter with LAT-1, and go to WAIT.
REQ-023 WAIT: counter SHALL decrement each cycle; on the cycle the counter reads 0, SHALL capture dp_en and dp_eni into res_en and res_eni, and go to HOLD.
REQ-024 End-to-end timing SHALL be: dp_start high at cycle T, capture at T+LAT, res_valid high at T+LAT+1.
REQ-025 HOLD: res_valid SHALL be high and res_tag, res_en and res_eni SHALL be stable until res_valid & res_ready.
REQ-026 On that handshake SHALL return to IDLE; a new grant SHALL be possible in the next cycle, never in the same cycle.
REQ-027 dp_* operand outputs SHALL hold their last value outside ISSUE and WAIT.
REQ-028 req_ready SHALL be 0 in ISSUE, WAIT and HOLD; requests not granted SHALL be held by their requester, with no loss and no queuing inside the block.
REQ-029 req_valid dropping after grant SHALL NOT affect the operation in flight.
REQ-030 Counter SHALL be 4 bits; it SHALL never wrap, because LAT-1 is at most 14.

Reset
REQ-031 rst SHALL take precedence over all other inputs and SHALL abort any in-flight operation without a result.
REQ-032 Reset state SHALL be: FSM IDLE, round-robin pointer selecting bit 0, counter 0, req_ready 0, dp_start 0, res_valid 0.
REQ-033 Reset state SHALL also clear all data outputs to 0, including res_tag, res_en, res_eni and all dp_* outputs.
REQ-034 rst asserted in WAIT SHALL NOT be followed by res_valid until a new grant completes.

Configuration
REQ-035 Macro ROUND_ARBITER_STATS_EN SHALL, when defined, add outputs grant_cnt0 and grant_cnt1 (16 bits each).
REQ-036 The grant counters SHALL increment on each grant to their requester, saturate at 16'hFFFF, and clear on rst.
REQ-037 Without the macro, these ports and their counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-038 Package fpu_round_pkg SHALL hold the FSM state enum, EXP_W=11 and LZ_W=6, for sharing with the rounder datapath.
REQ-039 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant: inputs req[1:0] and advance; output one-hot gnt[1:0]; registered priority pointer.

Verification
REQ-040 Single request: req_valid=01 at cycle 0 with er=0x3FF, lz=3 -> req_ready=01 at cycle 0, dp_start at cycle 1, res_valid at cycle 1+LAT+1 (cycle 4 with LAT=2), res_tag=0, res_en equal to the dp_en captured at cycle 3.
REQ-041 Contention: req_valid=11 held for 3 operations -> grants in order 0, 1, 0 and res_tag sequence 0, 1, 0.
REQ-042 Backpressure: res_ready=0 for 5 cycles in HOLD -> res_valid stays 1, res_en stable, req_ready stays 00, no further dp_start.
REQ-043 Reset mid-op: rst pulsed at cycle 2 of WAIT -> all outputs 0 in the next cycle and no res_valid until a new request completes.
REQ-044 LAT=1 build: dp_start at T -> res_valid at T+2; with res_ready=1, the back-to-back grant follows in the cycle after the handshake.
REQ-045 STATS build: 70000 grants to requester 0 -> grant_cnt0=16'hFFFF and grant_cnt1 equal to requester 1's actual grant count.
